// File: rtl/alu_pkg.sv
// Shared opcode and sequencer-state types for the single-bit ALU slice and
// the bit-serial sequencer built around it.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND      = 3'd0,
    OP_NOT      = 3'd1,
    OP_OR       = 3'd2,
    OP_XOR      = 3'd3,
    OP_ADD      = 3'd4,
    OP_SUB      = 3'd5,
    OP_TRANSFER = 3'd6,
    OP_TEST     = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } serial_state_e;

  // Only the arithmetic opcodes produce a meaningful final carry/borrow.
  function automatic logic is_arith(alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu1.sv
// One-bit ALU slice: combinational result bit plus carry (ADD) or borrow (SUB).
module alu1
  import alu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    carry_in,
  input  alu_op_e op,
  output logic    y,
  output logic    carry_out
);

  always_comb begin
    y         = 1'b0;
    carry_out = 1'b0;
    case (op)
      OP_AND:      y = a & b;
      OP_NOT:      y = ~a;
      OP_OR:       y = a | b;
      OP_XOR:      y = a ^ b;
      OP_ADD: begin
        y         = a ^ b ^ carry_in;
        carry_out = (a & b) | (a & carry_in) | (b & carry_in);
      end
      OP_SUB: begin
        // carry_in/carry_out act as borrow-in/borrow-out
        y         = a ^ b ^ carry_in;
        carry_out = (~a & (b | carry_in)) | (b & carry_in);
      end
      OP_TRANSFER: y = a;
      OP_TEST:     y = ~(a ^ b);
      default: begin
        y         = 1'b0;
        carry_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU sequencer: feeds one alu1 slice LSB-first and assembles a
// WIDTH-bit result plus final carry/borrow in WIDTH+2 cycles per operation.
//
// state | meaning
// IDLE  | ready high, waiting for start
// RUN   | one operand bit per clock through alu1, carry held in c
// DONE  | result/carry_out just loaded, done pulse high
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int RW = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  serial_state_e    state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [RW-1:0]    res_sh_q, res_sh_d;
  alu_op_e          op_q, op_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             done_q, done_d;

  logic bit_y;
  logic bit_c;

  alu1 u_alu1 (
    .a         (a_sh_q[0]),
    .b         (b_sh_q[0]),
    .carry_in  (c_q),
    .op        (op_q),
    .y         (bit_y),
    .carry_out (bit_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      op_q        <= OP_AND;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_sh_q    <= res_sh_d;
      op_q        <= op_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_sh_d    = res_sh_q;
    op_d        = op_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    done_d      = 1'b0;
    ready       = (state_q == ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = alu_op_e'(select);
          c_d     = carry_in;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // res_sh only needs the first WIDTH-1 bits; the last one goes straight to result
        res_sh_d = (res_sh_q >> 1) | (RW'(bit_y) << (RW - 1));
        c_d      = bit_c;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d     = ST_DONE;
          result_d    = {bit_y, res_sh_q};
          carry_out_d = is_arith(op_q) ? bit_c : 1'b0;
          done_d      = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial: directed table, random ops, corner
// sequences and an exhaustive back-to-back sweep against an arithmetic model.
module tb_alu_serial;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_res;
    logic         exp_cout;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   select;
  logic         carry_in;
  logic [W-1:0] result;
  logic         carry_out;
  logic         done;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  alu_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ready     (ready),
    .a         (a),
    .b         (b),
    .select    (select),
    .carry_in  (carry_in),
    .result    (result),
    .carry_out (carry_out),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Returns {carry, result} computed with plain integer arithmetic.
  function automatic logic [W:0] ref_model(int op, int av, int bv, int cin);
    int r;
    logic c;
    c = 1'b0;
    case (op)
      0: r = av & bv;
      1: r = ~av & MASK;
      2: r = av | bv;
      3: r = av ^ bv;
      4: begin r = av + bv + cin; c = (r > MASK); end
      5: begin r = av - bv - cin; c = (r < 0); end
      6: r = av;
      default: r = ~(av ^ bv) & MASK;
    endcase
    r = r & MASK;
    return {c, r[W-1:0]};
  endfunction

  // Accepts one op, then watches WIDTH+3 cycles: first done index, done count,
  // and whether ready stayed low from the accept cycle through the done cycle.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic cin,
                       output int done_at, output int ndone, output bit rdy_low);
    int waitc;
    @(negedge clk);
    waitc = 0;
    while (!ready && waitc < 10) begin @(negedge clk); waitc++; end
    if (!ready) check("ready_before_op", 0, 1);
    start = 1'b1; a = av; b = bv; select = op; carry_in = cin;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~av; b = ~bv; select = ~op; carry_in = ~cin;
    done_at = -1; ndone = 0; rdy_low = 1'b1;
    for (int k = 0; k < W + 3; k++) begin
      if (k > 0) @(negedge clk);
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if (k <= W && ready) rdy_low = 1'b0;
    end
  endtask

  vec_t tbl[$];

  initial begin
    int done_at, ndone;
    bit rdy_low;
    logic [W:0] m;
    int ok, prev_done, waitc;
    logic [11:0] idx;

    tbl.push_back('{3'd4, 4'hB, 4'h6, 1'b0, 4'h1, 1'b1});
    tbl.push_back('{3'd5, 4'h3, 4'h5, 1'b0, 4'hE, 1'b1});
    tbl.push_back('{3'd5, 4'h9, 4'h4, 1'b1, 4'h4, 1'b0});
    tbl.push_back('{3'd7, 4'hA, 4'h3, 1'b0, 4'h6, 1'b0});
    tbl.push_back('{3'd1, 4'h5, 4'h0, 1'b0, 4'hA, 1'b0});
    tbl.push_back('{3'd0, 4'hC, 4'hA, 1'b1, 4'h8, 1'b0});
    tbl.push_back('{3'd2, 4'hC, 4'h3, 1'b1, 4'hF, 1'b0});
    tbl.push_back('{3'd3, 4'hF, 4'h5, 1'b0, 4'hA, 1'b0});
    tbl.push_back('{3'd6, 4'h7, 4'h9, 1'b1, 4'h7, 1'b0});
    tbl.push_back('{3'd4, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1});
    tbl.push_back('{3'd5, 4'h0, 4'h0, 1'b1, 4'hF, 1'b1});
    tbl.push_back('{3'd4, 4'h2, 4'h3, 1'b1, 4'h6, 1'b0});

    rst_n = 1'b0; start = 1'b1; a = 4'hF; b = 4'hF; select = 3'd4; carry_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", carry_out, 0);
    start = 1'b0;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, done_at, ndone, rdy_low);
      check($sformatf("tbl%0d_result", i), result, tbl[i].exp_res);
      check($sformatf("tbl%0d_cout", i), carry_out, tbl[i].exp_cout);
      check($sformatf("tbl%0d_done_at", i), done_at, W);
      check($sformatf("tbl%0d_ndone", i), ndone, 1);
      check($sformatf("tbl%0d_ready_low", i), rdy_low, 1);
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op; logic [W-1:0] av, bv; logic cin;
      op = 3'($urandom_range(7)); av = W'($urandom); bv = W'($urandom); cin = 1'($urandom);
      m = ref_model(op, av, bv, cin);
      do_op(op, av, bv, cin, done_at, ndone, rdy_low);
      check($sformatf("rnd%0d_result", i), result, m[W-1:0]);
      check($sformatf("rnd%0d_cout", i), carry_out, m[W]);
      check($sformatf("rnd%0d_done_at", i), done_at, W);
    end

    // start pulsed during RUN with different operands must be ignored
    @(negedge clk);
    start = 1'b1; a = 4'hB; b = 4'h6; select = 3'd4; carry_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ok = ready ? 0 : 1;
    @(negedge clk);
    start = 1'b1; a = 4'h1; b = 4'h1; select = 3'd0; carry_in = 1'b1;
    if (ready) ok = 0;
    @(negedge clk);
    start = 1'b0;
    done_at = -1;
    for (int k = 2; k < 8; k++) begin
      if (done && done_at < 0) done_at = k;
      if (done_at < 0 && ready) ok = 0;
      @(negedge clk);
    end
    check("ign_done_at", done_at, W);
    check("ign_ready_low", ok, 1);
    check("ign_result", result, 1);
    check("ign_cout", carry_out, 1);
    check("ign_no_second_op", ready, 1);

    // reset after E2 of an ADD aborts without a done pulse
    start = 1'b1; a = 4'h7; b = 4'h7; select = 3'd4; carry_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_result", result, 0);
    check("abort_cout", carry_out, 0);
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_ready_after", ready, 1);
    do_op(3'd4, 4'h5, 4'h9, 1'b1, done_at, ndone, rdy_low);
    check("post_abort_result", result, 4'hF);
    check("post_abort_cout", carry_out, 0);
    check("post_abort_done_at", done_at, W);

    // exhaustive, start held high, operands changed right after each accept
    @(negedge clk);
    idx = 12'd0;
    select = idx[11:9]; a = idx[8:5]; b = idx[4:1]; carry_in = idx[0];
    start = 1'b1;
    prev_done = -1;
    for (int n = 0; n < 4096; n++) begin
      logic [2:0] op; logic [W-1:0] av, bv; logic cin;
      idx = 12'(n);
      op = idx[11:9]; av = idx[8:5]; bv = idx[4:1]; cin = idx[0];
      waitc = 0;
      while (!ready && waitc < 10) begin @(negedge clk); waitc++; end
      if (!ready) begin check("exh_ready_timeout", 0, 1); break; end
      @(posedge clk);
      #1;
      if (n < 4095) begin
        idx = 12'(n + 1);
        select = idx[11:9]; a = idx[8:5]; b = idx[4:1]; carry_in = idx[0];
      end else begin
        start = 1'b0;
      end
      waitc = 0;
      @(negedge clk);
      while (!done && waitc < 10) begin @(negedge clk); waitc++; end
      if (!done) begin check("exh_done_timeout", 0, 1); break; end
      m = ref_model(op, av, bv, cin);
      check($sformatf("exh%0d_result", n), result, m[W-1:0]);
      check($sformatf("exh%0d_cout", n), carry_out, m[W]);
      if (prev_done >= 0) check($sformatf("exh%0d_spacing", n), cyc - prev_done, W + 2);
      prev_done = cyc;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/alu_serial.md
# alu_serial

Bit-serial operation sequencer placed directly upstream of `alu1`. Accepts WIDTH-bit operands plus an opcode through a ready/start handshake and presents the operands to a single `alu1` slice one bit per clock, LSB first. Between bits it stores the slice's carry/borrow in a register, then assembles the WIDTH-bit result and final carry. It gives the design a WIDTH-bit ALU that costs one slice and WIDTH+2 cycles per operation.

## Interface
- WIDTH, 4, operand/result width; legal range ≥ 2
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low; the only clock, one reset domain
- start  in  1  request; accepted on a rising edge where start && ready
- ready  out  1  block idle, can accept (combinational from state)
- a  in  WIDTH  operand A, sampled at accept
- b  in  WIDTH  operand B, sampled at accept
- select  in  3  opcode, sampled at accept: 0 AND, 1 NOT, 2 OR, 3 XOR, 4 ADD, 5 SUB, 6 TRANSFER, 7 TEST
- carry_in  in  1  initial carry (ADD) / borrow (SUB), sampled at accept
- result  out  WIDTH  final result register
- carry_out  out  1  final carry (ADD) / borrow (SUB); 0 for all other opcodes
- done  out  1  one-cycle pulse: result/carry_out just updated

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on accept.
  - RUN→DONE on the edge where the bit count equals WIDTH-1.
  - DONE→IDLE unconditionally.
- ready = (state == IDLE). start is ignored in RUN and DONE; requests are not queued.
- On accept, latch:
  - a, b into shift registers
  - select into op register
  - carry_in into carry register c
  - count to 0
- Each RUN cycle:
  - Drive alu1 with a_sh[0], b_sh[0], c and op.
  - On the edge:
    - Shift a_sh and b_sh right.
    - Shift alu1 out into the MSB of the internal res_sh.
    - Set c to alu1 carry_out.
    - Increment count.
- Per-bit semantics (from alu1):
  - NOT = ~a
  - TRANSFER = a
  - TEST = XNOR(a, b) per bit, no reduction
  - ADD = a+b+c
  - SUB = a−b−borrow, with carry_out as borrow
- Final edge of RUN:
  - result ← completed res_sh, bit 0 in the LSB.
  - carry_out ← alu1 carry_out if op ∈ {ADD, SUB}, else 0.
- result and carry_out hold their values until the next operation completes. They never show partial values.
- Arithmetic is modulo 2^WIDTH. Overflow is reported only through carry_out; no sign flag.
- Operand or opcode changes after accept have no effect on the operation in flight.

## Timing
- Reset (rst_n low, asynchronous):
  - state IDLE, count 0, c 0
  - result 0, carry_out 0, done 0
  - ready 1 (from state)
  - start is not acted on while rst_n is low.
- Accept at edge E0. Bits 0..WIDTH-1 are processed at edges E1..EWIDTH.
- result, carry_out and done=1 are visible after EWIDTH. done falls after EWIDTH+1, when ready returns to 1.
- Earliest next accept: EWIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- Reset mid-RUN or mid-DONE:
  - Abort immediately; no done pulse.
  - result and carry_out clear to 0.
  - ready = 1 after reset release.
- start held high continuously: one operation every WIDTH+2 cycles, each using the operands present at its accept edge.

## Structure
- Shared `alu_pkg`, used by alu1 and alu_serial:
  - `alu_op_e` opcode enum (AND..TEST, 3 bits)
  - state typedef `serial_state_e` (IDLE, RUN, DONE)
- Counter width: $clog2(WIDTH).
- One sub-module: a single `alu1` instance, driven from the shift-register LSBs and c. No other hierarchy.

## Test plan
- ADD, a=0xB, b=0x6, carry_in=0, accept at E0 -> done high only in the cycle after E4; result=0x1, carry_out=1.
- SUB, a=0x3, b=0x5, carry_in=0 -> result=0xE, carry_out=1. Then SUB, a=0x9, b=0x4, carry_in=1 -> result=0x4, carry_out=0.
- TEST, a=0xA, b=0x3 -> result=0x6, carry_out=0. NOT, a=0x5 -> result=0xA, carry_out=0.
- start pulsed in RUN with different operands -> ignored; result matches the first operation; ready low from E0 through the done cycle.
- rst_n low after E2 of an ADD -> no done; result=0, carry_out=0, ready=1; a new ADD accepted after release completes correctly.
- Exhaustive: all 8 opcodes × all a, b × both carry_in values, back-to-back with start held high -> each result and carry_out matches the reference model; each done spaced exactly 6 cycles apart.
